// File: rtl/instruction_fetch_stage_pkg.sv
// Shared fetch-stage definitions: reset PC, bubble encoding and next-PC selection.
// The bubble constant is also used by the later pipeline-register flush logic.
package instruction_fetch_stage_pkg;

   localparam int unsigned instr_width = 32;

   localparam logic [31:0] reset_pc_value = 32'h0000_0000;

   // ADDI x0,x0,0
   localparam logic [instr_width-1:0] nop_instruction = 32'h0000_0013;

   typedef enum logic [1:0] {
      PcSelReset,
      PcSelRedirect,
      PcSelHold,
      PcSelSeq
   } pc_sel_e;

   // Redirect outranks stall: the branch in EX is older than the stalled consumer in ID.
   function automatic pc_sel_e select_next_pc(input logic rst, input logic redirect,
                                              input logic stall);
      pc_sel_e sel;
      if (rst) begin
         sel = PcSelReset;
      end else if (redirect) begin
         sel = PcSelRedirect;
      end else if (stall) begin
         sel = PcSelHold;
      end else begin
         sel = PcSelSeq;
      end
      return sel;
   endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register: captures the fetched word with its PC, holds on stall and
// loads a bubble on reset or flush.
module if_id_register
   import instruction_fetch_stage_pkg::*;
#(
   parameter int unsigned            data_width = 32,
   parameter logic [data_width-1:0]  nop_instr  = nop_instruction
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [data_width-1:0] fetch_instruction,
   input  logic [data_width-1:0] fetch_pc,
   input  logic [data_width-1:0] fetch_pc_plus4,
   output logic [data_width-1:0] instruction,
   output logic [data_width-1:0] pc,
   output logic [data_width-1:0] pc_plus4,
   output logic                  valid
);

   logic [data_width-1:0] instruction_q, instruction_d;
   logic [data_width-1:0] pc_q, pc_d;
   logic [data_width-1:0] pc_plus4_q, pc_plus4_d;
   logic                  valid_q, valid_d;

   always_comb begin
      instruction_d = instruction_q;
      pc_d          = pc_q;
      pc_plus4_d    = pc_plus4_q;
      valid_d       = valid_q;
      if (flush) begin
         instruction_d = nop_instr;
         pc_d          = '0;
         pc_plus4_d    = '0;
         valid_d       = 1'b0;
      end else if (!stall) begin
         instruction_d = fetch_instruction;
         pc_d          = fetch_pc;
         pc_plus4_d    = fetch_pc_plus4;
         valid_d       = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instruction_q <= nop_instr;
         pc_q          <= '0;
         pc_plus4_q    <= '0;
         valid_q       <= 1'b0;
      end else begin
         instruction_q <= instruction_d;
         pc_q          <= pc_d;
         pc_plus4_q    <= pc_plus4_d;
         valid_q       <= valid_d;
      end
   end

   assign instruction = instruction_q;
   assign pc          = pc_q;
   assign pc_plus4    = pc_plus4_q;
   assign valid       = valid_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register, +4 adder, next-PC mux and the IF/ID register.
// Instruction memory is read asynchronously at the current PC.
module instruction_fetch_stage
   import instruction_fetch_stage_pkg::*;
#(
   parameter int unsigned            data_width = 32,
   parameter logic [data_width-1:0]  reset_pc   = reset_pc_value,
   parameter logic [data_width-1:0]  nop_instr  = nop_instruction
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [data_width-1:0] branch_target,
   output logic [data_width-1:0] imem_addr,
   input  logic [data_width-1:0] imem_rdata,
   output logic [data_width-1:0] pc,
   output logic [data_width-1:0] if_id_instruction,
   output logic [data_width-1:0] if_id_pc,
   output logic [data_width-1:0] if_id_pc_plus4,
   output logic                  if_id_valid
);

   localparam logic [data_width-1:0] pc_step = data_width'(4);

   pc_sel_e               pc_sel;
   logic [data_width-1:0] pc_q, pc_d;
   logic [data_width-1:0] pc_plus4;
   logic [data_width-1:0] aligned_target;

   // Target low bits are dropped rather than trapped; keep them visibly consumed.
   logic unused_target_bits;
   assign unused_target_bits = ^branch_target[1:0];

   assign aligned_target = {branch_target[data_width-1:2], 2'b00};
   assign pc_plus4       = pc_q + pc_step;

   always_comb begin
      pc_sel = select_next_pc(rst, redirect, stall);
   end

   always_comb begin
      pc_d = pc_q;
      unique case (pc_sel)
         PcSelReset:    pc_d = reset_pc;
         PcSelRedirect: pc_d = aligned_target;
         PcSelHold:     pc_d = pc_q;
         PcSelSeq:      pc_d = pc_plus4;
         default:       pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= reset_pc;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc        = pc_q;
   assign imem_addr = pc_q;

   if_id_register #(
      .data_width (data_width),
      .nop_instr  (nop_instr)
   ) u_if_id (
      .clk               (clk),
      .rst               (rst),
      .stall             (stall),
      .flush             (redirect),
      .fetch_instruction (imem_rdata),
      .fetch_pc          (pc_q),
      .fetch_pc_plus4    (pc_plus4),
      .instruction       (if_id_instruction),
      .pc                (if_id_pc),
      .pc_plus4          (if_id_pc_plus4),
      .valid             (if_id_valid)
   );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: scoreboard of expected post-edge state,
// plus a second instance exercising PC wrap from the top of the address space.
module tb_instruction_fetch_stage;

   logic        clk = 1'b0;
   logic        rst, stall, redirect;
   logic [31:0] branch_target;
   logic [31:0] imem_addr, imem_rdata, pc;
   logic [31:0] if_id_instruction, if_id_pc, if_id_pc_plus4;
   logic        if_id_valid;

   logic        rst_w;
   logic [31:0] w_imem_addr, w_imem_rdata, w_pc;
   logic [31:0] w_instruction, w_if_pc, w_if_plus4;
   logic        w_valid;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] ifpc;
      logic [31:0] plus4;
      logic        valid;
   } exp_t;

   exp_t sb[$];

   // Bench model state
   logic [31:0] m_pc, m_instr, m_ifpc, m_plus4;
   logic        m_valid;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      case (addr)
         32'h0:   return 32'h0050_0093;
         32'h4:   return 32'h00A0_0113;
         32'h8:   return 32'h0020_81B3;
         32'hC:   return 32'h0000_0013;
         default: return 32'hC0DE_0000 | (addr & 32'h0000_FFFF);
      endcase
   endfunction

   assign imem_rdata   = mem_word(imem_addr);
   assign w_imem_rdata = mem_word(w_imem_addr);

   always #5 clk = ~clk;

   instruction_fetch_stage dut (
      .clk               (clk),
      .rst               (rst),
      .stall             (stall),
      .redirect          (redirect),
      .branch_target     (branch_target),
      .imem_addr         (imem_addr),
      .imem_rdata        (imem_rdata),
      .pc                (pc),
      .if_id_instruction (if_id_instruction),
      .if_id_pc          (if_id_pc),
      .if_id_pc_plus4    (if_id_pc_plus4),
      .if_id_valid       (if_id_valid)
   );

   instruction_fetch_stage #(
      .reset_pc (32'hFFFF_FFFC)
   ) dut_wrap (
      .clk               (clk),
      .rst               (rst_w),
      .stall             (1'b0),
      .redirect          (1'b0),
      .branch_target     (32'h0),
      .imem_addr         (w_imem_addr),
      .imem_rdata        (w_imem_rdata),
      .pc                (w_pc),
      .if_id_instruction (w_instruction),
      .if_id_pc          (w_if_pc),
      .if_id_pc_plus4    (w_if_plus4),
      .if_id_valid       (w_valid)
   );

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, push the model's prediction, then compare after the edge.
   task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] tgt);
      exp_t e;
      exp_t got;
      rst = r;
      stall = s;
      redirect = rd;
      branch_target = tgt;
      if (r) begin
         m_pc = 32'h0;
         m_instr = 32'h13; m_ifpc = 32'h0; m_plus4 = 32'h0; m_valid = 1'b0;
      end else if (rd) begin
         m_pc = tgt & 32'hFFFF_FFFC;
         m_instr = 32'h13; m_ifpc = 32'h0; m_plus4 = 32'h0; m_valid = 1'b0;
      end else if (!s) begin
         m_instr = mem_word(m_pc);
         m_ifpc  = m_pc;
         m_plus4 = m_pc + 32'd4;
         m_valid = 1'b1;
         m_pc    = m_pc + 32'd4;
      end
      e = '{pc: m_pc, instr: m_instr, ifpc: m_ifpc, plus4: m_plus4, valid: m_valid};
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         got = sb.pop_front();
         check("pc", pc, got.pc);
         check("imem_addr", imem_addr, got.pc);
         check("if_id_instruction", if_id_instruction, got.instr);
         check("if_id_pc", if_id_pc, got.ifpc);
         check("if_id_pc_plus4", if_id_pc_plus4, got.plus4);
         check("if_id_valid", {31'd0, if_id_valid}, {31'd0, got.valid});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; branch_target = 32'h0; rst_w = 1'b1;
      m_pc = 32'h0; m_instr = 32'h13; m_ifpc = 32'h0; m_plus4 = 32'h0; m_valid = 1'b0;
      @(posedge clk);
      #1;

      // Reset state
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("reset_pc", pc, 32'h0);
      check("reset_instr", if_id_instruction, 32'h0000_0013);
      check("reset_valid", {31'd0, if_id_valid}, 32'd0);

      // Sequential run of four cycles
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
      check("run_pc", pc, 32'h10);
      check("run_ifpc", if_id_pc, 32'hC);
      check("run_instr", if_id_instruction, 32'h0000_0013);

      // Stall at pc = 8 for two cycles, then resume
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      check("stall_pc", pc, 32'h8);
      check("stall_ifpc", if_id_pc, 32'h4);
      check("stall_instr", if_id_instruction, 32'h00A0_0113);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check("resume_pc", pc, 32'hC);
      check("resume_ifpc", if_id_pc, 32'h8);

      // Redirect from pc = C to 0x40
      step(1'b0, 1'b0, 1'b1, 32'h40);
      check("redirect_pc", pc, 32'h40);
      check("redirect_bubble", if_id_instruction, 32'h0000_0013);
      check("redirect_valid", {31'd0, if_id_valid}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check("target_ifpc", if_id_pc, 32'h40);
      check("target_instr", if_id_instruction, 32'hC0DE_0040);

      // Redirect and stall together, misaligned target
      step(1'b0, 1'b1, 1'b1, 32'h21);
      check("redirect_stall_pc", pc, 32'h20);
      check("redirect_stall_valid", {31'd0, if_id_valid}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'h0);

      // Reset during a stall at pc = 0x40
      step(1'b0, 1'b0, 1'b1, 32'h40);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      check("prereset_pc", pc, 32'h40);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("rst_stall_pc", pc, 32'h0);
      check("rst_stall_plus4", if_id_pc_plus4, 32'h0);

      // Wrap instance: reset at 0xFFFFFFFC, then one sequential fetch
      rst = 1'b1;
      check("wrap_reset_pc", w_pc, 32'hFFFF_FFFC);
      check("wrap_reset_addr", w_imem_addr, 32'hFFFF_FFFC);
      rst_w = 1'b0;
      @(posedge clk);
      #1;
      check("wrap_pc", w_pc, 32'h0);
      check("wrap_ifpc", w_if_pc, 32'hFFFF_FFFC);
      check("wrap_plus4", w_if_plus4, 32'h0);
      check("wrap_instr", w_instruction, 32'hC0DE_FFFC);
      check("wrap_valid", {31'd0, w_valid}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Fetch stage of the 5-stage RISC-V pipeline. Holds the program counter, drives the instruction-memory address and captures the fetched word into the IF/ID pipeline register. The immediate generator and decoder in ID consume its outputs. Handles sequential fetch, branch redirect from EX, load-use stalls and branch flushes.

## Interface
Parameters:
- data_width, 32, width of PC, instruction and all data ports
- reset_pc, 32'h0000_0000, PC value loaded on reset
- nop_instr, 32'h0000_0013, bubble instruction (ADDI x0,x0,0) inserted on flush/reset

Ports:
- clk  input  1  pipeline clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hazard unit load-use stall; hold PC and IF/ID
- redirect  input  1  branch taken, resolved in EX; load branch_target, flush IF/ID
- branch_target  input  data_width  redirect PC from EX
- imem_addr  output  data_width  byte address to instruction memory (= pc)
- imem_rdata  input  data_width  instruction word, asynchronous read of imem_addr
- pc  output  data_width  current fetch PC
- if_id_instruction  output  data_width  instruction to ID stage
- if_id_pc  output  data_width  PC of if_id_instruction
- if_id_pc_plus4  output  data_width  if_id_pc + 4
- if_id_valid  output  1  1 = real instruction, 0 = bubble

## Operation
- Next-PC select, priority high to low: rst -> reset_pc; redirect -> {branch_target[data_width-1:2], 2'b00}; stall -> pc (hold); else pc + 4.
- IF/ID update, same priority: rst or redirect -> instruction = nop_instr, pc = 0, pc_plus4 = 0, valid = 0; stall -> hold all fields; else instruction = imem_rdata, pc = pc, pc_plus4 = pc + 4, valid = 1.
- redirect and stall together: redirect wins (branch is older than the stalled load consumer); PC loads target and IF/ID is flushed.
- PC arithmetic is modulo 2^data_width; pc + 4 from 32'hFFFF_FFFC wraps to 32'h0000_0000, no flag.
- Misaligned branch_target: bits [1:0] are silently cleared; no exception.
- imem_addr = pc combinationally; no registered output path to memory.
- Two-state fetch behaviour, no explicit FSM beyond the PC/IF-ID registers: RUN (advance) and HOLD (stall). Redirect is a one-cycle event from either.

## Timing
- Reset values: pc = reset_pc, imem_addr = reset_pc, if_id_instruction = nop_instr, if_id_pc = 0, if_id_pc_plus4 = 0, if_id_valid = 0.
- First cycle after rst deasserts: memory returns word at reset_pc; it appears on if_id_* one edge later. Fetch-to-ID latency is 1 cycle.
- Redirect asserted in cycle N: edge N+1 gives pc = target and IF/ID = bubble; target instruction on if_id_* after edge N+2. Penalty: the flushed IF/ID slot, plus the EX-stage flush, which is owned by the ID/EX register.
- Stall held for k cycles: pc and if_id_* unchanged for k edges; sequential fetch resumes on the first edge with stall = 0.
- rst mid-stall or mid-redirect: rst dominates on that edge; all registers take reset values.
- Inputs stall, redirect and branch_target are sampled on the rising edge only. Glitches within the cycle are ignored.

## Structure
- Shared package: reset_pc default, nop_instr constant (also used by the ID/EX flush logic), instruction width constant.
- Sub-module if_id_register: holds the instruction, pc, pc_plus4 and valid fields, with stall (hold) and flush (bubble) controls. It is reused in style by the later pipeline registers.
- Top contains the PC register, the +4 adder and the next-PC mux.

## Test plan
- Reset then run 4 cycles, memory = {0x00500093, 0x00A00113, 0x002081B3, 0x00000013} at 0x0..0xC -> pc steps 0,4,8,C,10. if_id_instruction lags by one cycle. if_id_pc_plus4 = if_id_pc + 4. valid = 1 after the first fetch.
- stall = 1 for 2 cycles at pc = 8 -> pc stays 8, if_id_pc stays 4 with instruction 0x00A00113. Resume -> pc = C, if_id_pc = 8.
- redirect = 1 with target 0x40 at pc = C -> next edge pc = 0x40, if_id_instruction = 0x00000013 with valid = 0. The following edge gives if_id_pc = 0x40.
- redirect and stall both high, target 0x21 -> pc = 0x20 (bits cleared), IF/ID flushed, stall ignored.
- rst asserted during a stall at pc = 0x40 -> pc = reset_pc and all if_id_* at their reset values on that edge.
- Wrap test, reset_pc = 0xFFFFFFFC -> second pc = 0x00000000. The first if_id_pc_plus4 = 0x00000000.
